timer_scheduler: RTL and testbench
==================================

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: idle cycles inserted after each service before the next arbitration (0 permitted).
REQ-002 SHALL have port clk_104mhz  input  1  system clock, 104 MHz; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  4  level request, one bit per requester 0..3.
REQ-005 SHALL have port req_value  input  16  countdown length per requester; requester i uses bits [4i+3:4i].
REQ-006 SHALL have port cancel  input  4  abort request for requester i's in-service countdown.
REQ-007 SHALL have port timer_expired  input  1  one-cycle expiry pulse from the shared countdown timer.
REQ-008 SHALL have port timer_countdown  input  4  current countdown position from the shared timer.
REQ-009 SHALL have port start_timer  output  1  one-cycle pulse that starts the shared timer.
REQ-010 SHALL have port timer_value  output  4  countdown length presented to the shared timer.
REQ-011 SHALL have port grant  output  4  one-hot, or zero, identifying the requester in service.
REQ-012 SHALL have port done  output  4  one-cycle pulse on bit i when requester i's countdown expires.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port countdown_out  output  4  timer_countdown while grant is nonzero, else 0.

Function
REQ-015 SHALL implement states IDLE, START, WAIT and GAP, with all outputs registered except countdown_out.
REQ-016 IDLE: if req is nonzero, SHALL pick the winner by round-robin starting at (last_served+1) mod 4, set grant[winner], latch timer_value from req_value[winner], and go to START; otherwise SHALL remain in IDLE with grant=0.
REQ-017 START: SHALL assert start_timer for exactly one cycle, update last_served to the winner, and go to WAIT.
REQ-018 WAIT: on timer_expired, SHALL pulse done[winner] for one cycle, clear grant, and go to GAP, or go directly to IDLE when GAP_CYCLES=0.
REQ-019 WAIT: on cancel[winner] without timer_expired, SHALL clear grant, assert no done, and leave WAIT as in REQ-018.
REQ-020 If cancel[winner] and timer_expired occur in the same cycle, expiry SHALL win and done[winner] SHALL pulse.
REQ-021 cancel bits for non-granted requesters, and all cancel bits outside WAIT, SHALL be ignored.
REQ-022 timer_expired SHALL be ignored in IDLE, START and GAP, since stale pulses from a cancelled run must not produce done.
REQ-023 Deasserting req after grant SHALL NOT affect service; req is sampled only in IDLE.
REQ-024 GAP: SHALL hold for exactly GAP_CYCLES cycles, counted by an internal counter sized for GAP_CYCLES, then go to IDLE.
REQ-025 A requester holding req continuously SHALL be re-served only after every other active requester has been served once.
REQ-026 Requested value 0 SHALL be passed through unchanged; the resulting expiry completes service normally.
REQ-027 Latency from req assertion in IDLE to start_timer SHALL be 2 cycles, and from timer_expired to the done pulse SHALL be 1 cycle.
REQ-028 Any encoding of an illegal state SHALL return to IDLE on the next cycle with grant=0.

Reset
REQ-029 While reset is high at a clock edge, the block SHALL enter IDLE, clear the GAP counter, and set last_served=3 so requester 0 has highest priority.
REQ-030 During reset, start_timer, timer_value, grant, done and busy SHALL all be 0.
REQ-031 Reset asserted mid-WAIT SHALL abort service without a done pulse; a later timer_expired SHALL be ignored.

Verification
REQ-032 Single request: req=0001, value=3, timer stubbed to expire 5 cycles after start -> grant=0001, start_timer 2 cycles after req, done=0001 one cycle after expiry, busy low after 2 GAP cycles.
REQ-033 Round-robin: req=1111 held, values 1,2,3,4 -> service order 0,1,2,3,0 with timer_value matching each requester.
REQ-034 Cancel: requester 2 granted, cancel=0100 in WAIT -> grant=0 next cycle, no done; a later stale timer_expired produces no done.
REQ-035 Simultaneous cancel and expiry for the granted requester in one cycle -> done pulse asserted.
REQ-036 Reset mid-WAIT with req=0010 -> all outputs 0; after release, requester 1 served first (start_timer 2 cycles after release).
REQ-037 GAP_CYCLES=0 and value 0 -> WAIT returns straight to IDLE; back-to-back services with no idle cycle besides IDLE.

Source files
------------

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one countdown timer among four requesters.
// Each service: arbitrate in IDLE, pulse start_timer from START, wait for
// expiry or cancel in WAIT, then an optional GAP of GAP_CYCLES idle cycles.
module timer_scheduler #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk_104mhz,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] req_value,
    input  logic [3:0]  cancel,
    input  logic        timer_expired,
    input  logic [3:0]  timer_countdown,
    output logic        start_timer,
    output logic [3:0]  timer_value,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic [3:0]  countdown_out
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    winner, winner_nx;
    logic [1:0]    last_served, last_nx;
    logic [GW-1:0] gap_cnt, gap_cnt_nx;
    logic          start_nx;
    logic [3:0]    value_nx;
    logic [3:0]    grant_nx;
    logic [3:0]    done_nx;
    logic          busy_nx;

    logic          rr_hit;
    logic [1:0]    rr_pick;
    logic [1:0]    rr_idx;

    // Round-robin search: first active requester after last_served.
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = last_served;
        rr_idx  = last_served;
        for (int unsigned k = 1; k <= 4; k++) begin
            rr_idx = last_served + 2'(k);
            if (!rr_hit && req[rr_idx]) begin
                rr_hit  = 1'b1;
                rr_pick = rr_idx;
            end
        end
    end

    // Next-state and next registered-output values.
    always_comb begin
        state_nx   = state;
        winner_nx  = winner;
        last_nx    = last_served;
        gap_cnt_nx = gap_cnt;
        start_nx   = 1'b0;
        value_nx   = timer_value;
        grant_nx   = grant;
        done_nx    = '0;
        case (state)
            IDLE: begin
                grant_nx = '0;
                if (rr_hit) begin
                    winner_nx = rr_pick;
                    grant_nx  = 4'b0001 << rr_pick;
                    value_nx  = req_value[{rr_pick, 2'b00} +: 4];
                    state_nx  = START;
                end
            end
            START: begin
                start_nx = 1'b1;
                last_nx  = winner;
                state_nx = WAIT;
            end
            WAIT: begin
                // Expiry takes precedence over a same-cycle cancel.
                if (timer_expired || cancel[winner]) begin
                    grant_nx        = '0;
                    done_nx[winner] = timer_expired;
                    gap_cnt_nx      = '0;
                    state_nx        = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_104mhz) begin
        if (reset) begin
            state       <= IDLE;
            winner      <= '0;
            last_served <= 2'd3;
            gap_cnt     <= '0;
            start_timer <= 1'b0;
            timer_value <= '0;
            grant       <= '0;
            done        <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            winner      <= winner_nx;
            last_served <= last_nx;
            gap_cnt     <= gap_cnt_nx;
            start_timer <= start_nx;
            timer_value <= value_nx;
            grant       <= grant_nx;
            done        <= done_nx;
            busy        <= busy_nx;
        end
    end

    // Countdown pass-through only while someone holds the grant.
    always_comb begin
        countdown_out = (grant != '0) ? timer_countdown : '0;
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: two instances (GAP_CYCLES=2 and 0)
// share request stimulus; each has its own timer stub. A behavioural model
// is checked every cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_timer_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_value;
    logic [3:0]  cancel;

    logic [1:0]      texp = '0;
    logic [1:0][3:0] tcd  = '0;
    logic [1:0]      st;
    logic [1:0][3:0] tv;
    logic [1:0][3:0] gr;
    logic [1:0][3:0] dn;
    logic [1:0]      bz;
    logic [1:0][3:0] cd;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    timer_scheduler #(.GAP_CYCLES(2)) u_dut (
        .clk_104mhz(clk), .reset(reset), .req(req), .req_value(req_value),
        .cancel(cancel), .timer_expired(texp[0]), .timer_countdown(tcd[0]),
        .start_timer(st[0]), .timer_value(tv[0]), .grant(gr[0]),
        .done(dn[0]), .busy(bz[0]), .countdown_out(cd[0])
    );

    timer_scheduler #(.GAP_CYCLES(0)) u_dut0 (
        .clk_104mhz(clk), .reset(reset), .req(req), .req_value(req_value),
        .cancel(cancel), .timer_expired(texp[1]), .timer_countdown(tcd[1]),
        .start_timer(st[1]), .timer_value(tv[1]), .grant(gr[1]),
        .done(dn[1]), .busy(bz[1]), .countdown_out(cd[1])
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Timer stub: expires timer_value+2 cycles after it sees start_timer.
    int s_left[2] = '{0, 0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) s_left[d] = 0;
            else if (st[d]) s_left[d] = int'(tv[d]) + 2;
            else if (s_left[d] > 0) s_left[d] = s_left[d] - 1;
            texp[d] = (s_left[d] == 1);
            tcd[d]  = 4'(s_left[d]);
        end
    end

    // Behavioural model: owner index, service phase, gap countdown.
    localparam int P_FREE = 0, P_ARMED = 1, P_RUN = 2, P_GAP = 3;
    int         m_owner[2];
    int         m_phase[2];
    int         m_last[2];
    int         m_gap[2];
    logic [3:0] m_value[2];
    logic       m_start[2];
    logic [3:0] m_done[2];
    logic [3:0] exp_grant;

    task automatic model_step(input int d);
        int g;
        int i;
        g = (d == 0) ? 2 : 0;
        m_start[d] = 1'b0;
        m_done[d]  = 4'b0;
        if (reset) begin
            m_owner[d] = -1; m_phase[d] = P_FREE; m_last[d] = 3;
            m_gap[d] = 0; m_value[d] = 4'd0;
        end else begin
            case (m_phase[d])
                P_FREE: begin
                    m_owner[d] = -1;
                    if (req != 4'b0) begin
                        for (int k = 1; k <= 4; k++) begin
                            i = (m_last[d] + k) % 4;
                            if (m_owner[d] < 0 && req[i]) m_owner[d] = i;
                        end
                        m_value[d] = 4'((req_value >> (4 * m_owner[d])) & 16'hF);
                        m_phase[d] = P_ARMED;
                    end
                end
                P_ARMED: begin
                    m_start[d] = 1'b1;
                    m_last[d]  = m_owner[d];
                    m_phase[d] = P_RUN;
                end
                P_RUN: begin
                    if (texp[d] || cancel[m_owner[d]]) begin
                        if (texp[d]) m_done[d] = 4'(1 << m_owner[d]);
                        m_owner[d] = -1;
                        if (g == 0) m_phase[d] = P_FREE;
                        else begin m_phase[d] = P_GAP; m_gap[d] = g; end
                    end
                end
                default: begin
                    m_gap[d] = m_gap[d] - 1;
                    if (m_gap[d] == 0) m_phase[d] = P_FREE;
                end
            endcase
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        if (cmp_on) begin
            for (int d = 0; d < 2; d++) begin
                exp_grant = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0;
                chk($sformatf("d%0d grant", d), 16'(gr[d]), 16'(exp_grant));
                chk($sformatf("d%0d start", d), 16'(st[d]), 16'(m_start[d]));
                chk($sformatf("d%0d value", d), 16'(tv[d]), 16'(m_value[d]));
                chk($sformatf("d%0d done", d), 16'(dn[d]), 16'(m_done[d]));
                chk($sformatf("d%0d busy", d), 16'(bz[d]), 16'(m_phase[d] != P_FREE));
                chk($sformatf("d%0d countdown", d), 16'(cd[d]),
                    16'((exp_grant != 4'b0) ? tcd[d] : 4'b0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; req_value = '0; cancel = '0;
        tick(3);
        reset = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (st[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk(name, 16'(st[0]), 16'd1);
    endtask

    task automatic wait_done1(input string name);
        int n = 0;
        while (dn[1] === 4'b0 && n < 40) begin @(negedge clk); n++; end
        chk(name, 16'(n < 40), 16'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bz[0] !== 1'b0 || bz[1] !== 1'b0) && n < 40) begin @(negedge clk); n++; end
        chk(name, 16'({bz[1], bz[0]}), 16'd0);
    endtask

    logic [3:0] done_seen;

    initial begin
        reset = 1'b1; req = '0; req_value = '0; cancel = '0;
        tick(3);
        cmp_on = 1'b1;
        chk("reset grant", 16'(gr[0]), 16'h0);
        chk("reset busy", 16'(bz[0]), 16'h0);
        chk("reset start", 16'(st[0]), 16'h0);
        chk("reset value", 16'(tv[0]), 16'h0);
        chk("reset done", 16'(dn[0]), 16'h0);
        reset = 1'b0;

        // Single request, value 3, expiry 5 cycles after start.
        req = 4'b0001; req_value = 16'h0003;
        tick(1);
        chk("t1 grant", 16'(gr[0]), 16'h1);
        chk("t1 start early", 16'(st[0]), 16'h0);
        chk("t1 busy", 16'(bz[0]), 16'h1);
        req = 4'b0000;
        tick(1);
        chk("t1 start", 16'(st[0]), 16'h1);
        chk("t1 value", 16'(tv[0]), 16'h3);
        tick(5);
        chk("t1 done", 16'(dn[0]), 16'h1);
        chk("t1 grant cleared", 16'(gr[0]), 16'h0);
        chk("t1 gap busy", 16'(bz[0]), 16'h1);
        tick(1);
        chk("t1 done one cycle", 16'(dn[0]), 16'h0);
        chk("t1 gap busy 2", 16'(bz[0]), 16'h1);
        tick(1);
        chk("t1 idle", 16'(bz[0]), 16'h0);
        wait_idle("t1 settle");

        // Round-robin with all four requesting.
        do_reset();
        req = 4'b1111; req_value = 16'h4321;
        for (int s = 0; s < 5; s++) begin
            wait_start($sformatf("rr%0d start", s));
            chk($sformatf("rr%0d grant", s), 16'(gr[0]), 16'(4'b0001 << (s % 4)));
            chk($sformatf("rr%0d value", s), 16'(tv[0]), 16'((s % 4) + 1));
            if (s == 4) req = 4'b0000;
            tick(1);
        end
        wait_idle("rr settle");

        // Cancel: ignored outside WAIT and for other requesters; stale expiry ignored.
        do_reset();
        req = 4'b0100; req_value = 16'h0500; cancel = 4'b0100;
        tick(1);
        chk("cx grant", 16'(gr[0]), 16'h4);
        req = 4'b0000;
        tick(1);
        chk("cx start", 16'(st[0]), 16'h1);
        cancel = 4'b1011;
        tick(1);
        chk("cx other cancel", 16'(gr[0]), 16'h4);
        cancel = 4'b0100;
        tick(1);
        chk("cx grant cleared", 16'(gr[0]), 16'h0);
        chk("cx no done", 16'(dn[0]), 16'h0);
        cancel = 4'b0000;
        done_seen = 4'b0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            done_seen = done_seen | dn[0];
        end
        chk("cx stale expiry", 16'(done_seen), 16'h0);
        wait_idle("cx settle");

        // Cancel and expiry in the same cycle: done still pulses.
        do_reset();
        req = 4'b0001; req_value = 16'h0003;
        wait_start("sim start");
        req = 4'b0000;
        tick(4);
        cancel = 4'b0001;
        tick(1);
        chk("sim done", 16'(dn[0]), 16'h1);
        cancel = 4'b0000;
        wait_idle("sim settle");

        // Reset in WAIT, then requester 1 is served after release.
        do_reset();
        req = 4'b0010; req_value = 16'h0020;
        wait_start("rst start");
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("rst grant", 16'(gr[0]), 16'h0);
        chk("rst busy", 16'(bz[0]), 16'h0);
        chk("rst start", 16'(st[0]), 16'h0);
        chk("rst value", 16'(tv[0]), 16'h0);
        chk("rst done", 16'(dn[0]), 16'h0);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst rel grant", 16'(gr[0]), 16'h2);
        chk("rst rel start early", 16'(st[0]), 16'h0);
        tick(1);
        chk("rst rel start", 16'(st[0]), 16'h1);
        req = 4'b0000;
        wait_idle("rst settle");

        // GAP_CYCLES=0 with value 0: back-to-back services.
        do_reset();
        req = 4'b0011; req_value = 16'h0000;
        wait_done1("g0 first done");
        chk("g0 done0", 16'(dn[1]), 16'h1);
        chk("g0 idle", 16'(bz[1]), 16'h0);
        chk("g0 grant cleared", 16'(gr[1]), 16'h0);
        tick(1);
        chk("g0 next grant", 16'(gr[1]), 16'h2);
        chk("g0 busy", 16'(bz[1]), 16'h1);
        wait_done1("g0 second done");
        chk("g0 done1", 16'(dn[1]), 16'h2);
        tick(1);
        chk("g0 third grant", 16'(gr[1]), 16'h1);
        req = 4'b0000;
        wait_idle("g0 settle");

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
